cam_capture_ctrl: RTL

Sequences single-frame captures from the camera datapath into the shared 16-bit-address frame buffer and arbitrates that buffer's single port between the camera writer and a downstream reader (MNIST downsampler/VGA). On a start request it waits for a clean field boundary, passes camera writes for a fixed number of fields, then freezes the buffer and hands the port to the reader until released. It sits between the camera block's address_cam/data/we_cam outputs and the frame-buffer RAM.

---
 rtl/cam_capture_ctrl_if.sv | 32 +++
 rtl/cam_capture_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl_if.sv
// Frame-buffer port bundle: camera write bus, reader request/response and the RAM port.
interface cam_capture_ctrl_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 24;

    logic          cam_we;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_data;

    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    // Environment side: camera, reader and the RAM model.
    modport master (
        output cam_we, cam_addr, cam_data, rd_req, rd_addr, mem_rdata,
        input  rd_gnt, rd_valid, rd_data, mem_addr, mem_wdata, mem_we
    );

    // Controller side.
    modport slave (
        input  cam_we, cam_addr, cam_data, rd_req, rd_addr, mem_rdata,
        output rd_gnt, rd_valid, rd_data, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Single-frame capture sequencer and frame-buffer port arbiter between camera writer and reader.
// Frame handback input is named frame_release since "release" is a reserved word.
module cam_capture_ctrl #(
    parameter int unsigned   FIELDS  = 2,
    parameter int unsigned   TW      = 24,
    parameter logic [TW-1:0] TIMEOUT = TW'(1000000)
) (
    input  logic              clk_27,
    input  logic              reset,
    input  logic              start,
    input  logic              frame_release,
    input  logic              vid_vs,
    cam_capture_ctrl_if.slave bus,
    output logic              busy,
    output logic              frame_ready,
    output logic              timeout_err
);
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 24;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, HOLD} state_t;

    state_t        state, state_n;
    logic [CW-1:0] fcnt, fcnt_n, fcnt_inc;
    logic [TW-1:0] wdog, wdog_n, wdog_inc;
    logic          abort_n;
    logic          cam_own, rd_own;
    logic          vs_s1, vs_s2, vs_d, vs_rise;
    logic          gnt_q;
    logic [DW-1:0] rd_hold;

    assign vs_rise  = vs_s2 & ~vs_d;
    assign fcnt_inc = fcnt + CW'(1);
    assign wdog_inc = wdog + TW'(1);

    // Reader grant is combinational so a request is answered in the cycle it is made.
    assign bus.rd_gnt  = rd_own & bus.rd_req;
    // RAM output is presented directly in the valid cycle and held afterwards.
    assign bus.rd_data = bus.rd_valid ? bus.mem_rdata : rd_hold;

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        wdog_n  = '0;
        abort_n = 1'b0;
        cam_own = 1'b0;
        rd_own  = 1'b0;
        case (state)
            IDLE: begin
                rd_own = 1'b1;
                if (start) state_n = ARM;
            end
            ARM: begin
                wdog_n = wdog_inc;
                if (vs_rise) begin
                    state_n = CAPTURE;
                    fcnt_n  = '0;
                    wdog_n  = '0;
                end else if (wdog_inc == TIMEOUT) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                    fcnt_n  = '0;
                    wdog_n  = '0;
                end
            end
            CAPTURE: begin
                wdog_n  = wdog_inc;
                cam_own = 1'b1;
                if (vs_rise) begin
                    fcnt_n = fcnt_inc;
                    wdog_n = '0;
                    // The field boundary that completes the frame must not leak a write.
                    if (fcnt_inc == CW'(FIELDS)) begin
                        state_n = HOLD;
                        cam_own = 1'b0;
                    end
                end else if (wdog_inc == TIMEOUT) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                    cam_own = 1'b0;
                    fcnt_n  = '0;
                    wdog_n  = '0;
                end
            end
            HOLD: begin
                rd_own = 1'b1;
                if (start)              state_n = ARM;
                else if (frame_release) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_27) begin
        if (reset) begin
            state       <= IDLE;
            fcnt        <= '0;
            wdog        <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            frame_ready <= 1'b0;
            vs_s1       <= 1'b0;
            vs_s2       <= 1'b0;
            vs_d        <= 1'b0;
        end else begin
            state       <= state_n;
            fcnt        <= fcnt_n;
            wdog        <= wdog_n;
            timeout_err <= abort_n;
            busy        <= (state_n == ARM) || (state_n == CAPTURE);
            frame_ready <= (state_n == HOLD);
            vs_s1       <= vid_vs;
            vs_s2       <= vs_s1;
            vs_d        <= vs_s2;
        end
    end

    // Registered RAM port mux and read-return pipeline.
    always_ff @(posedge clk_27) begin
        if (reset) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rd_valid  <= 1'b0;
            gnt_q         <= 1'b0;
            rd_hold       <= '0;
        end else begin
            bus.mem_we <= cam_own & bus.cam_we;
            if (cam_own) begin
                bus.mem_addr  <= bus.cam_addr;
                bus.mem_wdata <= bus.cam_data;
            end else if (bus.rd_gnt) begin
                bus.mem_addr  <= bus.rd_addr;
            end
            gnt_q        <= bus.rd_gnt;
            bus.rd_valid <= gnt_q;
            if (bus.rd_valid) rd_hold <= bus.mem_rdata;
        end
    end
endmodule
